fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  IF stage of the 5-stage RISC-V pipeline. Owns the fetch PC, issues one
//  request at a time to a variable-latency instruction memory and holds the
//  returned word in a 1-entry output slot. The slot feeds pipeFD as InstrF/PCF/PCPlus4F.
//  Stalls and EX-stage redirects are honoured, including discard of in-flight responses.
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch address after reset (word aligned)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   asynchronous active-low reset
//  StallF     in   1   hazard unit: hold slot (pipeFD en low)
//  PCSrcE     in   1   redirect request from EX (taken branch/jump)
//  PCTargetE  in   32  redirect target; bits [1:0] ignored (forced 00)
//  ImemReq    out  1   request valid
//  ImemAddr   out  32  request word address
//  ImemGnt    in   1   request accepted this cycle (sampled only when ImemReq=1)
//  ImemRvalid in   1   response valid, earliest 1 cycle after grant
//  ImemRdata  in   32  response instruction
//  InstrF     out  32  slot instruction
//  PCF        out  32  PC of slot instruction
//  PCPlus4F   out  32  PCF+4, mod 2^32
//  ValidF     out  1   slot holds a live instruction; hazard unit clears pipeFD when 0
// BEHAVIOUR
//  - Reset (async, rst=0): state=REQ, fetch pc_q=RESET_PC, slot valid_q=0,
//    InstrF=0, PCF=0, PCPlus4F=4, ImemReq=0. The first request is issued on the
//    first cycle after rst deasserts.
//  - consume = ValidF & ~StallF & ~PCSrcE. valid_q is cleared on consume unless refilled the same edge.
//  - slot_free = ~valid_q | consume. ImemAddr=pc_q at all times.
//  - FSM, states REQ / WAIT / DROP; PCSrcE has priority over everything:
//    REQ : ImemReq = slot_free & ~PCSrcE-independent (i.e. = slot_free).
//          Gnt & ~PCSrcE -> pc_q<=pc_q+4, WAIT.
//          Gnt &  PCSrcE -> pc_q<=target, DROP.
//          ~Gnt & PCSrcE -> pc_q<=target, stay REQ. The address may change while ungranted.
//    WAIT: ImemReq=0. Rvalid & ~PCSrcE -> load slot {ImemRdata, pc_q-4}, valid_q=1, REQ.
//          Rvalid & PCSrcE -> discard response, pc_q<=target, REQ.
//          ~Rvalid & PCSrcE -> pc_q<=target, DROP.
//    DROP: ImemReq=0. Rvalid -> discard, REQ. PCSrcE -> pc_q<=target, stay DROP.
//  - Rvalid is ignored in REQ state.
//  - PCSrcE=1 clears valid_q on the next edge, in every state.
//  - The slot is guaranteed free when Rvalid arrives: a grant occurs only when slot_free.
//  - Throughput: 1 instr per (memory latency+1) cycles; with 1-cycle latency and
//    no stall, a request is issued every other cycle.
//  - pc_q+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000; no trap.
//  - Simultaneous StallF & PCSrcE: redirect wins, slot flushed.
//  - Reset mid-request: any later Rvalid for the pre-reset request is a memory-side
//    error and is not handled (the memory shares rst).
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds out ports FetchCnt[31:0] (+1 per consume) and
//    BubbleCnt[31:0] (+1 per cycle with ~ValidF & ~StallF). Both reset to 0 and wrap.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1. Reset RESET_PC=32'h100, 1-cycle memory, StallF=0: ImemAddr 100,104,108;
//     PCF/InstrF follow in order, ValidF every other cycle.
//  2. StallF=1 for 5 cycles with slot full (PCF=104): InstrF/PCF held, ImemReq=0.
//     Stall released: consume, request 108 in the same cycle.
//  3. 4-cycle latency; PCSrcE=1, PCTargetE=32'h200 in WAIT: response dropped, ValidF=0,
//     next ImemAddr=200, first valid PCF=200.
//  4. PCSrcE with Gnt in REQ (addr 10C): DROP, 10C response discarded, then request 200.
//  5. PCTargetE=32'h203: ImemAddr=200. pc_q=FFFF_FFFC granted -> next addr 0000_0000.
//     PCPlus4F=0 for PCF=FFFF_FFFC.
//  6. FETCH_PERF_CNT_EN defined: 10 instrs and 3 bubble cycles -> FetchCnt=10, BubbleCnt=3.
//     Async rst mid-WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: IF-stage fetch PC, single-outstanding instruction-memory request, 1-entry output slot.
// Optional build macro FETCH_PERF_CNT_EN adds FetchCnt/BubbleCnt performance counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemGnt,
  input  logic        ImemRvalid,
  input  logic [31:0] ImemRdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        ValidF
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FetchCnt,
  output logic [31:0] BubbleCnt
`endif
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] pcplus4_q, pcplus4_d;

  logic            consume;
  logic            slot_free;
  logic            load_slot;
  logic [XLEN-1:0] target;

  assign consume   = valid_q & ~StallF & ~PCSrcE;
  assign slot_free = ~valid_q | consume;
  assign target    = PCTargetE & ALIGN_MASK;
  assign ImemAddr  = pc_q;

  // Next-state, fetch PC and request; a redirect always overrides the fetch PC.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ImemReq   = 1'b0;
    load_slot = 1'b0;
    case (state_q)
      ST_REQ: begin
        ImemReq = slot_free & rst;
        if (PCSrcE) pc_d = target;
        if (ImemReq && ImemGnt) begin
          if (PCSrcE) begin
            state_d = ST_DROP;
          end else begin
            pc_d    = pc_q + PC_STEP;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (ImemRvalid) begin
          state_d = ST_REQ;
          if (PCSrcE) pc_d = target;
          else        load_slot = 1'b1;
        end else if (PCSrcE) begin
          pc_d    = target;
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (PCSrcE)     pc_d    = target;
        if (ImemRvalid) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase
  end

  // Slot: pc_q already points one word past the returning request, so PCF+4 == pc_q.
  always_comb begin
    valid_d   = valid_q;
    instr_d   = instr_q;
    pcf_d     = pcf_q;
    pcplus4_d = pcplus4_q;
    if (PCSrcE) begin
      valid_d = 1'b0;
    end else if (load_slot) begin
      valid_d   = 1'b1;
      instr_d   = ImemRdata;
      pcf_d     = pc_q - PC_STEP;
      pcplus4_d = pc_q;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_REQ;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      instr_q   <= '0;
      pcf_q     <= '0;
      pcplus4_q <= PC_STEP;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pcf_q     <= pcf_d;
      pcplus4_q <= pcplus4_d;
    end
  end

  assign InstrF   = instr_q;
  assign PCF      = pcf_q;
  assign PCPlus4F = pcplus4_q;
  assign ValidF   = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [XLEN-1:0] bubble_cnt_q, bubble_cnt_d;

  assign fetch_cnt_d  = consume ? fetch_cnt_q + XLEN'(1) : fetch_cnt_q;
  assign bubble_cnt_d = (~valid_q & ~StallF) ? bubble_cnt_q + XLEN'(1) : bubble_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign FetchCnt  = fetch_cnt_q;
  assign BubbleCnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized bench for fetch_unit with a transaction-level
// memory and slot reference model.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StallF = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemGnt = 1'b0;
  logic        ImemRvalid = 1'b0;
  logic [31:0] ImemRdata = '0;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        ValidF;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCnt;
  logic [31:0] BubbleCnt;
`endif

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk        (clk),
    .rst        (rst),
    .StallF     (StallF),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .ImemReq    (ImemReq),
    .ImemAddr   (ImemAddr),
    .ImemGnt    (ImemGnt),
    .ImemRvalid (ImemRvalid),
    .ImemRdata  (ImemRdata),
    .InstrF     (InstrF),
    .PCF        (PCF),
    .PCPlus4F   (PCPlus4F),
    .ValidF     (ValidF)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchCnt   (FetchCnt),
    .BubbleCnt  (BubbleCnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: slot contents, next fetch address, one outstanding memory transaction.
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_req_pc;
  logic        m_pend;
  logic        m_live;
  logic [31:0] m_pend_addr;
  int          m_cnt;
  int          lat;
  int unsigned m_fetch;
  int unsigned m_bubble;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_pc     = '0;
    m_instr  = '0;
    m_req_pc = RPC;
    m_pend   = 1'b0;
    m_live   = 1'b0;
    m_pend_addr = '0;
    m_cnt    = 0;
    m_fetch  = 0;
    m_bubble = 0;
  endtask

  // One clock: drive at the negedge, check 1 ns later, advance the model at the posedge.
  task automatic drive(input logic st, input logic rd, input logic [31:0] tgt, input logic gnt);
    logic consume, exp_req, grant, rvalid;
    StallF     = st;
    PCSrcE     = rd;
    PCTargetE  = tgt;
    ImemGnt    = gnt;
    rvalid     = m_pend && (m_cnt == 0);
    ImemRvalid = rvalid;
    ImemRdata  = rvalid ? mem_word(m_pend_addr) : $urandom;
    #1;
    consume = m_valid && !st && !rd;
    exp_req = !m_pend && (!m_valid || consume);
    chk("ImemReq", 32'(ImemReq), 32'(exp_req));
    chk("ValidF", 32'(ValidF), 32'(m_valid));
    if (m_valid) begin
      chk("PCF", PCF, m_pc);
      chk("InstrF", InstrF, m_instr);
      chk("PCPlus4F", PCPlus4F, m_pc + 32'd4);
    end
    if (exp_req) chk("ImemAddr", ImemAddr, m_req_pc);
    grant = exp_req && gnt;
    @(posedge clk);
    if (consume) m_fetch++;
    if (!m_valid && !st) m_bubble++;
    if (rd) begin
      m_valid = 1'b0;
    end else if (rvalid && m_live) begin
      m_valid = 1'b1;
      m_pc    = m_pend_addr;
      m_instr = mem_word(m_pend_addr);
    end else if (consume) begin
      m_valid = 1'b0;
    end
    if (rvalid) m_pend = 1'b0;
    else if (m_pend) m_cnt--;
    if (grant) begin
      m_pend      = 1'b1;
      m_cnt       = lat - 1;
      m_pend_addr = m_req_pc;
      m_live      = !rd;
    end else if (rd) begin
      m_live = 1'b0;
    end
    if (rd) m_req_pc = tgt & 32'hFFFF_FFFC;
    else if (grant) m_req_pc = m_req_pc + 32'd4;
    @(negedge clk);
  endtask

  task automatic await_valid(input logic [31:0] want_pc);
    for (int i = 0; i < 40 && !(m_valid && m_pc == want_pc); i++) drive(1'b0, 1'b0, '0, 1'b1);
    chk("await_valid", 32'(ValidF), 32'd1);
    chk("await_pcf", PCF, want_pc);
  endtask

  task automatic await_wait_state();
    for (int i = 0; i < 20 && !(m_pend && m_cnt > 0); i++) drive(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic check_counters(input string tag);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, "_FetchCnt"}, FetchCnt, m_fetch);
    chk({tag, "_BubbleCnt"}, BubbleCnt, m_bubble);
`endif
  endtask

  initial begin
    model_reset();
    lat = 1;
    #2 rst = 1'b0;
    #2;
    chk("rst_ValidF", 32'(ValidF), 32'd0);
    chk("rst_InstrF", InstrF, 32'd0);
    chk("rst_PCF", PCF, 32'd0);
    chk("rst_PCPlus4F", PCPlus4F, 32'd4);
    chk("rst_ImemReq", 32'(ImemReq), 32'd0);
    check_counters("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("first_req", 32'(ImemReq), 32'd1);
    chk("first_addr", ImemAddr, RPC);

    // Back-to-back 1-cycle memory, then a 5-cycle stall on PCF=104.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, '0, 1'b1);
    chk("pre_stall_pcf", PCF, 32'h104);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, '0, 1'b1);
    chk("stall_hold_pcf", PCF, 32'h104);
    chk("stall_hold_valid", 32'(ValidF), 32'd1);
    drive(1'b0, 1'b0, '0, 1'b1);
    await_valid(32'h108);

    // Redirect during WAIT with a 4-cycle memory.
    lat = 4;
    await_wait_state();
    drive(1'b0, 1'b1, 32'h200, 1'b1);
    chk("wait_redir_valid", 32'(ValidF), 32'd0);
    chk("wait_redir_addr", ImemAddr, 32'h200);
    await_valid(32'h200);

    // Redirect coincident with a grant in REQ.
    for (int i = 0; i < 20 && m_pend; i++) drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b1, 32'h200, 1'b1);
    await_valid(32'h200);

    // Misaligned target, then wrap of the fetch PC.
    drive(1'b0, 1'b1, 32'h203, 1'b0);
    chk("align_addr", ImemAddr, 32'h200);
    await_valid(32'h200);
    lat = 1;
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    await_valid(32'hFFFF_FFFC);
    chk("wrap_pcplus4", PCPlus4F, 32'd0);
    chk("wrap_addr", ImemAddr, 32'd0);
    drive(1'b1, 1'b1, 32'h300, 1'b1);
    chk("stall_redir_valid", 32'(ValidF), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      drive(($urandom % 4) == 0, ($urandom % 12) == 0, $urandom, ($urandom % 10) < 7);
    end
    check_counters("rand");

    // Asynchronous reset while a request is outstanding.
    lat = 4;
    await_wait_state();
    #2 rst = 1'b0;
    ImemRvalid = 1'b0;
    #1;
    model_reset();
    chk("arst_ValidF", 32'(ValidF), 32'd0);
    chk("arst_InstrF", InstrF, 32'd0);
    chk("arst_PCF", PCF, 32'd0);
    chk("arst_PCPlus4F", PCPlus4F, 32'd4);
    chk("arst_ImemReq", 32'(ImemReq), 32'd0);
    chk("arst_ImemAddr", ImemAddr, RPC);
    check_counters("arst");
    @(negedge clk);
    rst = 1'b1;
    lat = 1;
    await_valid(RPC);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, '0, 1'b1);
    check_counters("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
